// File: rtl/auto_bcd_counter.sv
// Multi-digit BCD counter with a two-rate prescaler, direction, enable, clear, load, tick and carry.
// Optional build macro AUTO_BCD_SAT_EN: saturate at all-9s / all-0s instead of wrapping.
module auto_bcd_counter #(
  parameter int DIGITS   = 4,
  parameter int DIV_FAST = 10_000_000,
  parameter int DIV_SLOW = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fast,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  carry
);

  localparam logic [PRE_W-1:0] LP_FAST_LAST = PRE_W'(DIV_FAST - 1);
  localparam logic [PRE_W-1:0] LP_SLOW_LAST = PRE_W'(DIV_SLOW - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [4*DIGITS-1:0] r_q;
  logic                r_tick;
  logic                r_carry;

  logic [PRE_W-1:0]    w_pre_last;
  logic                w_term;
  logic [4*DIGITS-1:0] w_q_inc;
  logic [4*DIGITS-1:0] w_q_dec;
  logic [4*DIGITS-1:0] w_q_step;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic                w_all9;
  logic                w_all0;
  logic                w_wrap;

  // The >= compare lets a switch to the shorter period end the current period at once.
  assign w_pre_last = fast ? LP_FAST_LAST : LP_SLOW_LAST;
  assign w_term     = en && (r_pre >= w_pre_last);

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic v_low9;
    logic v_low0;
    w_q_inc        = r_q;
    w_q_dec        = r_q;
    w_load_clamped = '0;
    v_low9         = 1'b1;
    v_low0         = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v_low9) begin
        w_q_inc[4*i +: 4] = (r_q[4*i +: 4] == 4'd9) ? 4'd0 : r_q[4*i +: 4] + 4'd1;
      end
      if (v_low0) begin
        w_q_dec[4*i +: 4] = (r_q[4*i +: 4] == 4'd0) ? 4'd9 : r_q[4*i +: 4] - 4'd1;
      end
      v_low9 = v_low9 && (r_q[4*i +: 4] == 4'd9);
      v_low0 = v_low0 && (r_q[4*i +: 4] == 4'd0);
      w_load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
    w_all9 = v_low9;
    w_all0 = v_low0;
  end

  assign w_wrap = up ? w_all9 : w_all0;

`ifdef AUTO_BCD_SAT_EN
  assign w_q_step = w_wrap ? r_q : (up ? w_q_inc : w_q_dec);
`else
  assign w_q_step = up ? w_q_inc : w_q_dec;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_q     <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (clr) begin
      r_pre   <= '0;
      r_q     <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      if (w_term) begin
        r_pre <= '0;
      end else if (en) begin
        r_pre <= r_pre + PRE_W'(1);
      end
      // A load wins over a coincident step but leaves the prescaler running.
      if (load) begin
        r_q     <= w_load_clamped;
        r_tick  <= 1'b0;
        r_carry <= 1'b0;
      end else if (w_term) begin
        r_q     <= w_q_step;
        r_tick  <= 1'b1;
        r_carry <= w_wrap;
      end else begin
        r_tick  <= 1'b0;
        r_carry <= 1'b0;
      end
    end
  end

  assign q     = r_q;
  assign tick  = r_tick;
  assign carry = r_carry;

endmodule

// File: tb/tb_auto_bcd_counter.sv
// Self-checking bench for auto_bcd_counter (DIGITS=2, DIV_FAST=4, DIV_SLOW=10).
// Reference model keeps the count as a plain integer 0..99.
module tb_auto_bcd_counter;

  localparam int DIGITS   = 2;
  localparam int DIV_FAST = 4;
  localparam int DIV_SLOW = 10;
  localparam int PRE_W    = 4;
  localparam int MAXV     = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, fast, up, clr, load;
  logic [7:0] load_val;
  logic [7:0] q;
  logic       tick, carry;

  int  n_checks = 0;
  int  n_fails  = 0;

  int  m_val = 0;
  int  m_pre = 0;
  bit  m_tick = 1'b0;
  bit  m_carry = 1'b0;

  auto_bcd_counter #(
    .DIGITS(DIGITS), .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .PRE_W(PRE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fast(fast), .up(up), .clr(clr),
    .load(load), .load_val(load_val), .q(q), .tick(tick), .carry(carry)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int lo, hi;
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    return hi * 10 + lo;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_tick = 1'b0; m_carry = 1'b0;
  endtask

  task automatic model_step();
    int  div;
    bit  term, wrap;
    div  = fast ? DIV_FAST : DIV_SLOW;
    term = en && (m_pre >= div - 1);
    if (clr) begin
      model_reset();
    end else begin
      if (term) m_pre = 0;
      else if (en) m_pre = m_pre + 1;
      if (load) begin
        m_val = clamp_val(load_val); m_tick = 1'b0; m_carry = 1'b0;
      end else if (term) begin
        wrap    = up ? (m_val == MAXV - 1) : (m_val == 0);
        m_tick  = 1'b1;
        m_carry = wrap;
`ifdef AUTO_BCD_SAT_EN
        if (!wrap) m_val = up ? m_val + 1 : m_val - 1;
`else
        m_val = up ? (m_val + 1) % MAXV : (m_val + MAXV - 1) % MAXV;
`endif
      end else begin
        m_tick = 1'b0; m_carry = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("q", q, to_bcd(m_val));
    check("tick", tick, m_tick);
    check("carry", carry, m_carry);
  endtask

  task automatic first_tick(input string tag, input int expect_n);
    int  n = 0;
    bit  seen = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      cyc();
      if (tick) begin seen = 1'b1; n = i; end
    end
    check(tag, n, expect_n);
  endtask

  task automatic run_until_pre(input string tag, input int target);
    bit hit = (m_pre == target);
    for (int i = 0; i < 30 && !hit; i++) begin
      cyc();
      hit = (m_pre == target);
    end
    check(tag, hit, 1'b1);
  endtask

  initial begin
    logic [7:0] saved;
    rst_n = 1'b0; en = 1'b1; fast = 1'b0; up = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = 8'h00;
    #12;
    check("reset_q", q, 8'h00);
    check("reset_tick", tick, 1'b0);
    check("reset_carry", carry, 1'b0);
    rst_n = 1'b1;
    first_tick("first_tick_after_reset", 10);

    // Asynchronous reset in mid-run, observed with no clock edge.
    repeat (13) cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_q", q, 8'h00);
    check("async_reset_tick", tick, 1'b0);
    check("async_reset_carry", carry, 1'b0);
    #2 rst_n = 1'b1;
    first_tick("first_tick_after_midrun_reset", 10);

    // Up wrap 98 -> 99 -> 00.
    fast = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'h98;
    cyc();
    load = 1'b0;
    repeat (14) cyc();

    // Down wrap 01 -> 00 -> 99.
    up = 1'b0; load = 1'b1; load_val = 8'h01;
    cyc();
    load = 1'b0;
    repeat (14) cyc();

    // Rate switch part way through a slow period.
    up = 1'b1; fast = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    run_until_pre("rate_switch_reach_pre7", 7);
    fast = 1'b1;
    cyc();
    check("rate_switch_tick", tick, 1'b1);
    repeat (9) cyc();

    // Enable low freezes count and prescaler.
    saved = q;
    en = 1'b0;
    repeat (20) cyc();
    check("en_freeze_q", q, saved);
    en = 1'b1;
    repeat (6) cyc();

    // Clear beats load.
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc();
    check("clr_over_load_q", q, 8'h00);
    clr = 1'b0; load = 1'b0;
    repeat (2) cyc();

    // Load on a terminal edge suppresses the tick.
    run_until_pre("load_term_reach_last", DIV_FAST - 1);
    load = 1'b1; load_val = 8'h42;
    cyc();
    check("load_term_tick", tick, 1'b0);
    check("load_term_q", q, 8'h42);

    // Digits above 9 clamp to 9.
    load_val = 8'hA3;
    cyc();
    check("load_clamp_q", q, 8'h93);
    load = 1'b0;
    repeat (4) cyc();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      fast     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) up = ~up;
      clr      = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 3);
      load_val = 8'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
